if_ex_pipe_regs: RTL and testbench
==================================

# if_ex_pipe_regs

Bundle of the three forward pipeline registers of the 5-stage MIPS-style core: IF/ID, ID/EX and EX/MEM. It holds instruction, control and data fields between stages. IF/ID supports stall (write enable) and flush for hazard and branch handling. ID/EX and EX/MEM load every cycle; bubbles are injected upstream by zeroing control inputs.

## Interface
Parameters: none (all widths fixed: data 32, register specifier 5, ALU op 3, PC page 4).

- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset; clears every register
- if_id_flush  input  1  clear IF/ID to all-zero (NOP) at next edge
- if_id_write  input  1  IF/ID load enable; 0 = hold (stall)
- if_id_instruction_in / if_id_instruction_out  in/out  32  fetched instruction
- if_id_pc_plus_4_in / if_id_pc_plus_4_out  in/out  32  PC+4 of that instruction
- if_id_pc_page_in / if_id_pc_page_out  in/out  4  PC[31:28] for jump target
- id_ex_mem_write, id_ex_mem_read, id_ex_reg_write, id_ex_reg_dst, id_ex_mem_to_reg, id_ex_alu_src (_in/_out)  in/out  1 each  control bits
- id_ex_alu_op_in / id_ex_alu_op_out  in/out  3  ALU operation code
- id_ex_read_data_1, id_ex_read_data_2 (_in/_out)  in/out  32 each  register-file operands
- id_ex_imm_ext_in / id_ex_imm_ext_out  in/out  32  sign-extended immediate
- id_ex_rs, id_ex_rt, id_ex_rd (_in/_out)  in/out  5 each  register specifiers
- ex_mem_mem_write, ex_mem_mem_read, ex_mem_reg_write, ex_mem_mem_to_reg (_in/_out)  in/out  1 each  control bits
- ex_mem_dst_reg_in / ex_mem_dst_reg_out  in/out  5  selected destination register
- ex_mem_alu_zero_in / ex_mem_alu_zero_out  in/out  1  ALU zero flag
- ex_mem_alu_result_in / ex_mem_alu_result_out  in/out  32  ALU result / memory address
- ex_mem_write_data_in / ex_mem_write_data_out  in/out  32  forwarded rt value for stores

## Operation
- Every `_out` is the registered copy of its `_in`; no combinational path from any input to any output.
- IF/ID per rising edge, priority order: rst low -> 0; else if_id_flush=1 -> all IF/ID fields 0 (instruction 0x00000000 = NOP), regardless of if_id_write; else if_id_write=1 -> load all three fields; else hold all fields.
- ID/EX: loads all fields every rising edge; no enable, no flush. Bubble = upstream drives control inputs to 0.
- EX/MEM: loads all fields every rising edge; no enable, no flush.
- Stages independent: stall/flush of IF/ID never affects ID/EX or EX/MEM.
- No arithmetic; widths pass through unchanged.

## Timing
- Latency: exactly 1 clk from `_in` to `_out` for each stage.
- Reset: rst low asynchronously forces every output to 0 immediately (no clock needed) and holds while low; first load on first rising edge after rst returns high.
- Reset mid-operation: in-flight contents discarded; no partial state.
- Flush and write asserted together: flush wins (output 0).
- if_id_write=0 for N cycles: IF/ID outputs stay constant for N edges, then load current inputs on first edge with write=1.
- Inputs sampled only at rising clk; glitches between edges invisible.

## Test plan
- Reset: drive all inputs nonzero, pull rst low asynchronously between edges -> all outputs 0 before next edge; release rst, next edge -> outputs equal inputs.
- IF/ID load: instruction_in=0x8C220004, pc_plus_4_in=0x00000008, page=0x0, write=1, flush=0 -> outputs match after one edge, not before.
- IF/ID stall: load 0x00221820, then write=0 with instruction_in=0xAC030008 for 3 edges -> output stays 0x00221820; write=1 -> 0xAC030008 next edge.
- IF/ID flush priority: flush=1, write=1, instruction_in=0x10220003 -> instruction_out=0, pc_plus_4_out=0, page_out=0.
- ID/EX pass-through: alu_op=3'b010, read_data_1=0x12345678, imm_ext=0xFFFFFFFC, rs=1, rt=2, rd=3, reg_write=1 -> all appear after one edge; zero control inputs next cycle -> control outputs 0 following edge.
- EX/MEM pass-through: alu_result=0x00000010, write_data=0xDEADBEEF, dst_reg=5, mem_write=1, alu_zero=1 -> registered next edge; unaffected by simultaneous IF/ID flush/stall.

Source files
------------

// File: rtl/if_ex_pipe_regs_if.sv
// rtl/if_ex_pipe_regs_if.sv - stage-boundary bundle for the IF/ID, ID/EX and EX/MEM registers
interface if_ex_pipe_regs_if;
    logic        if_id_flush;
    logic        if_id_write;
    logic [31:0] if_id_instruction_in;
    logic [31:0] if_id_instruction_out;
    logic [31:0] if_id_pc_plus_4_in;
    logic [31:0] if_id_pc_plus_4_out;
    logic [3:0]  if_id_pc_page_in;
    logic [3:0]  if_id_pc_page_out;

    logic        id_ex_mem_write_in;
    logic        id_ex_mem_write_out;
    logic        id_ex_mem_read_in;
    logic        id_ex_mem_read_out;
    logic        id_ex_reg_write_in;
    logic        id_ex_reg_write_out;
    logic        id_ex_reg_dst_in;
    logic        id_ex_reg_dst_out;
    logic        id_ex_mem_to_reg_in;
    logic        id_ex_mem_to_reg_out;
    logic        id_ex_alu_src_in;
    logic        id_ex_alu_src_out;
    logic [2:0]  id_ex_alu_op_in;
    logic [2:0]  id_ex_alu_op_out;
    logic [31:0] id_ex_read_data_1_in;
    logic [31:0] id_ex_read_data_1_out;
    logic [31:0] id_ex_read_data_2_in;
    logic [31:0] id_ex_read_data_2_out;
    logic [31:0] id_ex_imm_ext_in;
    logic [31:0] id_ex_imm_ext_out;
    logic [4:0]  id_ex_rs_in;
    logic [4:0]  id_ex_rs_out;
    logic [4:0]  id_ex_rt_in;
    logic [4:0]  id_ex_rt_out;
    logic [4:0]  id_ex_rd_in;
    logic [4:0]  id_ex_rd_out;

    logic        ex_mem_mem_write_in;
    logic        ex_mem_mem_write_out;
    logic        ex_mem_mem_read_in;
    logic        ex_mem_mem_read_out;
    logic        ex_mem_reg_write_in;
    logic        ex_mem_reg_write_out;
    logic        ex_mem_mem_to_reg_in;
    logic        ex_mem_mem_to_reg_out;
    logic [4:0]  ex_mem_dst_reg_in;
    logic [4:0]  ex_mem_dst_reg_out;
    logic        ex_mem_alu_zero_in;
    logic        ex_mem_alu_zero_out;
    logic [31:0] ex_mem_alu_result_in;
    logic [31:0] ex_mem_alu_result_out;
    logic [31:0] ex_mem_write_data_in;
    logic [31:0] ex_mem_write_data_out;

    modport master (
        output if_id_flush, if_id_write,
        output if_id_instruction_in, if_id_pc_plus_4_in, if_id_pc_page_in,
        input  if_id_instruction_out, if_id_pc_plus_4_out, if_id_pc_page_out,
        output id_ex_mem_write_in, id_ex_mem_read_in, id_ex_reg_write_in,
        output id_ex_reg_dst_in, id_ex_mem_to_reg_in, id_ex_alu_src_in, id_ex_alu_op_in,
        output id_ex_read_data_1_in, id_ex_read_data_2_in, id_ex_imm_ext_in,
        output id_ex_rs_in, id_ex_rt_in, id_ex_rd_in,
        input  id_ex_mem_write_out, id_ex_mem_read_out, id_ex_reg_write_out,
        input  id_ex_reg_dst_out, id_ex_mem_to_reg_out, id_ex_alu_src_out, id_ex_alu_op_out,
        input  id_ex_read_data_1_out, id_ex_read_data_2_out, id_ex_imm_ext_out,
        input  id_ex_rs_out, id_ex_rt_out, id_ex_rd_out,
        output ex_mem_mem_write_in, ex_mem_mem_read_in, ex_mem_reg_write_in, ex_mem_mem_to_reg_in,
        output ex_mem_dst_reg_in, ex_mem_alu_zero_in, ex_mem_alu_result_in, ex_mem_write_data_in,
        input  ex_mem_mem_write_out, ex_mem_mem_read_out, ex_mem_reg_write_out, ex_mem_mem_to_reg_out,
        input  ex_mem_dst_reg_out, ex_mem_alu_zero_out, ex_mem_alu_result_out, ex_mem_write_data_out
    );

    modport slave (
        input  if_id_flush, if_id_write,
        input  if_id_instruction_in, if_id_pc_plus_4_in, if_id_pc_page_in,
        output if_id_instruction_out, if_id_pc_plus_4_out, if_id_pc_page_out,
        input  id_ex_mem_write_in, id_ex_mem_read_in, id_ex_reg_write_in,
        input  id_ex_reg_dst_in, id_ex_mem_to_reg_in, id_ex_alu_src_in, id_ex_alu_op_in,
        input  id_ex_read_data_1_in, id_ex_read_data_2_in, id_ex_imm_ext_in,
        input  id_ex_rs_in, id_ex_rt_in, id_ex_rd_in,
        output id_ex_mem_write_out, id_ex_mem_read_out, id_ex_reg_write_out,
        output id_ex_reg_dst_out, id_ex_mem_to_reg_out, id_ex_alu_src_out, id_ex_alu_op_out,
        output id_ex_read_data_1_out, id_ex_read_data_2_out, id_ex_imm_ext_out,
        output id_ex_rs_out, id_ex_rt_out, id_ex_rd_out,
        input  ex_mem_mem_write_in, ex_mem_mem_read_in, ex_mem_reg_write_in, ex_mem_mem_to_reg_in,
        input  ex_mem_dst_reg_in, ex_mem_alu_zero_in, ex_mem_alu_result_in, ex_mem_write_data_in,
        output ex_mem_mem_write_out, ex_mem_mem_read_out, ex_mem_reg_write_out, ex_mem_mem_to_reg_out,
        output ex_mem_dst_reg_out, ex_mem_alu_zero_out, ex_mem_alu_result_out, ex_mem_write_data_out
    );
endinterface

// File: rtl/if_ex_pipe_regs.sv
// rtl/if_ex_pipe_regs.sv - IF/ID (stall/flush), ID/EX and EX/MEM forward pipeline registers
module if_ex_pipe_regs (
    input  logic              clk,
    input  logic              rst,
    if_ex_pipe_regs_if.slave  bus
);

    // Flush outranks write so a taken branch squashes even a stalled fetch slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.if_id_instruction_out <= '0;
            bus.if_id_pc_plus_4_out   <= '0;
            bus.if_id_pc_page_out     <= '0;
        end else if (bus.if_id_flush) begin
            bus.if_id_instruction_out <= '0;
            bus.if_id_pc_plus_4_out   <= '0;
            bus.if_id_pc_page_out     <= '0;
        end else if (bus.if_id_write) begin
            bus.if_id_instruction_out <= bus.if_id_instruction_in;
            bus.if_id_pc_plus_4_out   <= bus.if_id_pc_plus_4_in;
            bus.if_id_pc_page_out     <= bus.if_id_pc_page_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.id_ex_mem_write_out   <= 1'b0;
            bus.id_ex_mem_read_out    <= 1'b0;
            bus.id_ex_reg_write_out   <= 1'b0;
            bus.id_ex_reg_dst_out     <= 1'b0;
            bus.id_ex_mem_to_reg_out  <= 1'b0;
            bus.id_ex_alu_src_out     <= 1'b0;
            bus.id_ex_alu_op_out      <= '0;
            bus.id_ex_read_data_1_out <= '0;
            bus.id_ex_read_data_2_out <= '0;
            bus.id_ex_imm_ext_out     <= '0;
            bus.id_ex_rs_out          <= '0;
            bus.id_ex_rt_out          <= '0;
            bus.id_ex_rd_out          <= '0;
        end else begin
            bus.id_ex_mem_write_out   <= bus.id_ex_mem_write_in;
            bus.id_ex_mem_read_out    <= bus.id_ex_mem_read_in;
            bus.id_ex_reg_write_out   <= bus.id_ex_reg_write_in;
            bus.id_ex_reg_dst_out     <= bus.id_ex_reg_dst_in;
            bus.id_ex_mem_to_reg_out  <= bus.id_ex_mem_to_reg_in;
            bus.id_ex_alu_src_out     <= bus.id_ex_alu_src_in;
            bus.id_ex_alu_op_out      <= bus.id_ex_alu_op_in;
            bus.id_ex_read_data_1_out <= bus.id_ex_read_data_1_in;
            bus.id_ex_read_data_2_out <= bus.id_ex_read_data_2_in;
            bus.id_ex_imm_ext_out     <= bus.id_ex_imm_ext_in;
            bus.id_ex_rs_out          <= bus.id_ex_rs_in;
            bus.id_ex_rt_out          <= bus.id_ex_rt_in;
            bus.id_ex_rd_out          <= bus.id_ex_rd_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ex_mem_mem_write_out  <= 1'b0;
            bus.ex_mem_mem_read_out   <= 1'b0;
            bus.ex_mem_reg_write_out  <= 1'b0;
            bus.ex_mem_mem_to_reg_out <= 1'b0;
            bus.ex_mem_dst_reg_out    <= '0;
            bus.ex_mem_alu_zero_out   <= 1'b0;
            bus.ex_mem_alu_result_out <= '0;
            bus.ex_mem_write_data_out <= '0;
        end else begin
            bus.ex_mem_mem_write_out  <= bus.ex_mem_mem_write_in;
            bus.ex_mem_mem_read_out   <= bus.ex_mem_mem_read_in;
            bus.ex_mem_reg_write_out  <= bus.ex_mem_reg_write_in;
            bus.ex_mem_mem_to_reg_out <= bus.ex_mem_mem_to_reg_in;
            bus.ex_mem_dst_reg_out    <= bus.ex_mem_dst_reg_in;
            bus.ex_mem_alu_zero_out   <= bus.ex_mem_alu_zero_in;
            bus.ex_mem_alu_result_out <= bus.ex_mem_alu_result_in;
            bus.ex_mem_write_data_out <= bus.ex_mem_write_data_in;
        end
    end

endmodule

// File: tb/tb_if_ex_pipe_regs.sv
// tb/tb_if_ex_pipe_regs.sv - directed and random checks of the IF/ID, ID/EX, EX/MEM registers
module tb_if_ex_pipe_regs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    typedef struct {
        string        tag;
        logic [67:0]  ifid;
        logic [119:0] idex;
        logic [73:0]  exmem;
    } exp_t;

    exp_t        sb[$];
    logic [67:0] m_ifid = '0;

    if_ex_pipe_regs_if bus ();

    if_ex_pipe_regs u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [67:0] ifid_in();
        return {bus.if_id_instruction_in, bus.if_id_pc_plus_4_in, bus.if_id_pc_page_in};
    endfunction
    function automatic logic [67:0] ifid_out();
        return {bus.if_id_instruction_out, bus.if_id_pc_plus_4_out, bus.if_id_pc_page_out};
    endfunction
    function automatic logic [119:0] idex_in();
        return {bus.id_ex_mem_write_in, bus.id_ex_mem_read_in, bus.id_ex_reg_write_in,
                bus.id_ex_reg_dst_in, bus.id_ex_mem_to_reg_in, bus.id_ex_alu_src_in,
                bus.id_ex_alu_op_in, bus.id_ex_read_data_1_in, bus.id_ex_read_data_2_in,
                bus.id_ex_imm_ext_in, bus.id_ex_rs_in, bus.id_ex_rt_in, bus.id_ex_rd_in};
    endfunction
    function automatic logic [119:0] idex_out();
        return {bus.id_ex_mem_write_out, bus.id_ex_mem_read_out, bus.id_ex_reg_write_out,
                bus.id_ex_reg_dst_out, bus.id_ex_mem_to_reg_out, bus.id_ex_alu_src_out,
                bus.id_ex_alu_op_out, bus.id_ex_read_data_1_out, bus.id_ex_read_data_2_out,
                bus.id_ex_imm_ext_out, bus.id_ex_rs_out, bus.id_ex_rt_out, bus.id_ex_rd_out};
    endfunction
    function automatic logic [73:0] exmem_in();
        return {bus.ex_mem_mem_write_in, bus.ex_mem_mem_read_in, bus.ex_mem_reg_write_in,
                bus.ex_mem_mem_to_reg_in, bus.ex_mem_dst_reg_in, bus.ex_mem_alu_zero_in,
                bus.ex_mem_alu_result_in, bus.ex_mem_write_data_in};
    endfunction
    function automatic logic [73:0] exmem_out();
        return {bus.ex_mem_mem_write_out, bus.ex_mem_mem_read_out, bus.ex_mem_reg_write_out,
                bus.ex_mem_mem_to_reg_out, bus.ex_mem_dst_reg_out, bus.ex_mem_alu_zero_out,
                bus.ex_mem_alu_result_out, bus.ex_mem_write_data_out};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_ifid(input logic flush, input logic wr, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic [3:0] page);
        bus.if_id_flush          = flush;
        bus.if_id_write          = wr;
        bus.if_id_instruction_in = instr;
        bus.if_id_pc_plus_4_in   = pc4;
        bus.if_id_pc_page_in     = page;
    endtask

    task automatic set_idex(input logic [5:0] ctl, input logic [2:0] op, input logic [31:0] rd1,
                            input logic [31:0] rd2, input logic [31:0] imm,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        {bus.id_ex_mem_write_in, bus.id_ex_mem_read_in, bus.id_ex_reg_write_in,
         bus.id_ex_reg_dst_in, bus.id_ex_mem_to_reg_in, bus.id_ex_alu_src_in} = ctl;
        bus.id_ex_alu_op_in      = op;
        bus.id_ex_read_data_1_in = rd1;
        bus.id_ex_read_data_2_in = rd2;
        bus.id_ex_imm_ext_in     = imm;
        bus.id_ex_rs_in          = rs;
        bus.id_ex_rt_in          = rt;
        bus.id_ex_rd_in          = rd;
    endtask

    task automatic set_exmem(input logic [3:0] ctl, input logic [4:0] dst, input logic zero,
                             input logic [31:0] res, input logic [31:0] wdata);
        {bus.ex_mem_mem_write_in, bus.ex_mem_mem_read_in, bus.ex_mem_reg_write_in,
         bus.ex_mem_mem_to_reg_in} = ctl;
        bus.ex_mem_dst_reg_in    = dst;
        bus.ex_mem_alu_zero_in   = zero;
        bus.ex_mem_alu_result_in = res;
        bus.ex_mem_write_data_in = wdata;
    endtask

    // Push the expectation for the coming edge, then pop it once the DUT has clocked.
    task automatic cycle(input string tag);
        exp_t e;
        exp_t got;
        e.tag = tag;
        if (!rst) begin
            e.ifid  = '0;
            e.idex  = '0;
            e.exmem = '0;
        end else begin
            e.ifid  = bus.if_id_flush ? 68'd0 : (bus.if_id_write ? ifid_in() : m_ifid);
            e.idex  = idex_in();
            e.exmem = exmem_in();
        end
        m_ifid = e.ifid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.tag, "/ifid"},  128'(ifid_out()),  128'(got.ifid));
        chk({got.tag, "/idex"},  128'(idex_out()),  128'(got.idex));
        chk({got.tag, "/exmem"}, 128'(exmem_out()), 128'(got.exmem));
    endtask

    initial begin
        set_ifid(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_idex(6'h0, 3'h0, 32'h0, 32'h0, 32'h0, 5'h0, 5'h0, 5'h0);
        set_exmem(4'h0, 5'h0, 1'b0, 32'h0, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("reset/ifid",  128'(ifid_out()),  128'd0);
        chk("reset/idex",  128'(idex_out()),  128'd0);
        chk("reset/exmem", 128'(exmem_out()), 128'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        set_ifid(1'b0, 1'b1, 32'h8C220004, 32'h00000008, 4'h0);
        #1 chk("load_before_edge", 128'(ifid_out()), 128'(m_ifid));
        cycle("load");

        set_ifid(1'b0, 1'b1, 32'h00221820, 32'h0000000C, 4'h1);
        cycle("stall_pre");
        set_ifid(1'b0, 1'b0, 32'hAC030008, 32'h00000010, 4'h2);
        set_exmem(4'b1000, 5'd5, 1'b1, 32'h00000010, 32'hDEADBEEF);
        cycle("stall1");
        set_exmem(4'b0110, 5'd7, 1'b0, 32'h00000020, 32'hCAFEF00D);
        cycle("stall2");
        cycle("stall3");
        chk("stall_instr_held", 128'(bus.if_id_instruction_out), 128'(32'h00221820));
        set_ifid(1'b0, 1'b1, 32'hAC030008, 32'h00000010, 4'h2);
        cycle("stall_release");
        chk("stall_release_instr", 128'(bus.if_id_instruction_out), 128'(32'hAC030008));

        set_idex(6'b001000, 3'b010, 32'h12345678, 32'h0000ABCD, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd3);
        cycle("idex_pass");
        set_idex(6'b000000, 3'b000, 32'h12345678, 32'h0000ABCD, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd3);
        cycle("idex_bubble");

        set_ifid(1'b1, 1'b1, 32'h10220003, 32'h00000014, 4'hF);
        set_exmem(4'b1000, 5'd5, 1'b1, 32'h00000010, 32'hDEADBEEF);
        cycle("flush_prio");
        chk("flush_instr_zero", 128'(bus.if_id_instruction_out), 128'd0);
        set_ifid(1'b1, 1'b0, 32'h10220003, 32'h00000014, 4'hF);
        cycle("flush_no_write");

        for (int i = 0; i < 24; i++) begin
            set_ifid(1'($urandom_range(4, 0) == 0), 1'($urandom_range(3, 0) != 0),
                     $urandom, $urandom, 4'($urandom));
            set_idex(6'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                     5'($urandom), 5'($urandom), 5'($urandom));
            set_exmem(4'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom);
            cycle("random");
        end

        set_ifid(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF);
        set_idex(6'h3F, 3'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F, 5'h1F, 5'h1F);
        set_exmem(4'hF, 5'h1F, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cycle("pre_async_rst");
        #2 rst = 1'b0;
        #1;
        chk("async_rst/ifid",  128'(ifid_out()),  128'd0);
        chk("async_rst/idex",  128'(idex_out()),  128'd0);
        chk("async_rst/exmem", 128'(exmem_out()), 128'd0);
        m_ifid = '0;
        cycle("rst_held");
        rst = 1'b1;
        cycle("rst_release");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
